// File: rtl/urng_pkg.sv
// Shared definitions for the URNG seed controller: default seeds, Tausworthe
// seed minimums, FSM state encoding and configuration addresses.
package urng_pkg;

    localparam logic [31:0] DEF_SEED0 = 32'h1F2E_3D4C;
    localparam logic [31:0] DEF_SEED1 = 32'h5B6A_7988;
    localparam logic [31:0] DEF_SEED2 = 32'h9C8D_7E6F;
    localparam logic [31:0] DEF_SEED3 = 32'h2468_ACE0;
    localparam logic [31:0] DEF_SEED4 = 32'h1357_9BDF;
    localparam logic [31:0] DEF_SEED5 = 32'hFEDC_BA98;

    // A Tausworthe component degenerates if its seed is below these bounds.
    localparam logic [31:0] SEED_MIN_A = 32'd2;
    localparam logic [31:0] SEED_MIN_B = 32'd8;
    localparam logic [31:0] SEED_MIN_C = 32'd16;

    localparam logic [2:0] CFG_ADDR_SEED_MAX = 3'd5;
    localparam logic [2:0] CFG_ADDR_LIMIT    = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WARM = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/urng_seed_regfile.sv
// Six 32-bit seed registers with write port and combinational legality check.
module urng_seed_regfile
    import urng_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] s0,
    output logic [31:0] s1,
    output logic [31:0] s2,
    output logic [31:0] s3,
    output logic [31:0] s4,
    output logic [31:0] s5,
    output logic        seed_ok
);

    logic [31:0] seed_q [6];
    logic [31:0] seed_d [6];

    always_comb begin
        for (int unsigned i = 0; i < 6; i++) begin
            seed_d[i] = seed_q[i];
        end
        if (we && addr <= CFG_ADDR_SEED_MAX) begin
            seed_d[addr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seed_q[0] <= DEF_SEED0;
            seed_q[1] <= DEF_SEED1;
            seed_q[2] <= DEF_SEED2;
            seed_q[3] <= DEF_SEED3;
            seed_q[4] <= DEF_SEED4;
            seed_q[5] <= DEF_SEED5;
        end else begin
            for (int unsigned i = 0; i < 6; i++) begin
                seed_q[i] <= seed_d[i];
            end
        end
    end

    assign s0 = seed_q[0];
    assign s1 = seed_q[1];
    assign s2 = seed_q[2];
    assign s3 = seed_q[3];
    assign s4 = seed_q[4];
    assign s5 = seed_q[5];

    assign seed_ok = (seed_q[0] >= SEED_MIN_A) && (seed_q[3] >= SEED_MIN_A) &&
                     (seed_q[1] >= SEED_MIN_B) && (seed_q[4] >= SEED_MIN_B) &&
                     (seed_q[2] >= SEED_MIN_C) && (seed_q[5] >= SEED_MIN_C);

endmodule

// File: rtl/urng_seed_ctrl.sv
// Seed-load / warm-up / run sequencer for the dual-Tausworthe URNG pair.
// Optional macro SAMPLE_LIMIT_EN adds a sample-limit register and DONE state.
module urng_seed_ctrl
    import urng_pkg::*;
#(
    parameter int WARMUP   = 16,
    parameter int LOAD_CYC = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    input  logic             start,
    input  logic             stop,
    output logic [31:0]      s0,
    output logic [31:0]      s1,
    output logic [31:0]      s2,
    output logic [31:0]      s3,
    output logic [31:0]      s4,
    output logic [31:0]      s5,
    output logic             taus_rst,
    output logic             u_valid,
    output logic             busy,
    output logic             seed_err,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam int PH_W = $clog2((WARMUP > LOAD_CYC) ? WARMUP : LOAD_CYC) + 1;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   cnt_q, cnt_d;
    logic              taus_rst_q, taus_rst_d;
    logic              u_valid_q, u_valid_d;
    logic              busy_q, busy_d;
    logic              seed_err_q, seed_err_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic              seed_ok;
    logic              cfg_ok;

    assign cfg_ok = cfg_we && (state_q == ST_IDLE);

    urng_seed_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (cfg_ok),
        .addr    (cfg_addr),
        .wdata   (cfg_wdata),
        .s0      (s0),
        .s1      (s1),
        .s2      (s2),
        .s3      (s3),
        .s4      (s4),
        .s5      (s5),
        .seed_ok (seed_ok)
    );

`ifdef SAMPLE_LIMIT_EN
    logic [CNT_W-1:0] limit_q, limit_d;

    always_comb begin
        limit_d = limit_q;
        if (cfg_ok && cfg_addr == CFG_ADDR_LIMIT) begin
            limit_d = cfg_wdata[CNT_W-1:0];
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        taus_rst_d   = taus_rst_q;
        u_valid_d    = u_valid_q;
        seed_err_d   = seed_err_q;
        sample_cnt_d = sample_cnt_q;

        if (u_valid_q && sample_cnt_q != '1) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                taus_rst_d = 1'b1;
                u_valid_d  = 1'b0;
`ifndef SAMPLE_LIMIT_EN
                state_d    = ST_IDLE;
`endif
                if (start) begin
                    if (seed_ok) begin
                        state_d      = ST_LOAD;
                        cnt_d        = '0;
                        seed_err_d   = 1'b0;
                        sample_cnt_d = '0;
                    end else begin
                        state_d    = ST_IDLE;
                        seed_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (cnt_q == PH_W'(LOAD_CYC - 1)) begin
                    state_d    = ST_WARM;
                    cnt_d      = '0;
                    taus_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WARM: begin
                if (cnt_q == PH_W'(WARMUP - 1)) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    u_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
`ifdef SAMPLE_LIMIT_EN
                // Compare the post-increment count so exactly 'limit' valid cycles are issued.
                if (limit_q != '0 && sample_cnt_d == limit_q) begin
                    state_d    = ST_DONE;
                    u_valid_d  = 1'b0;
                    taus_rst_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d    = ST_IDLE;
                taus_rst_d = 1'b1;
                u_valid_d  = 1'b0;
            end
        endcase

        if (stop && state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            u_valid_d  = 1'b0;
            taus_rst_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            taus_rst_q   <= 1'b1;
            u_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            seed_err_q   <= 1'b0;
            sample_cnt_q <= '0;
`ifdef SAMPLE_LIMIT_EN
            limit_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            taus_rst_q   <= taus_rst_d;
            u_valid_q    <= u_valid_d;
            busy_q       <= busy_d;
            seed_err_q   <= seed_err_d;
            sample_cnt_q <= sample_cnt_d;
`ifdef SAMPLE_LIMIT_EN
            limit_q      <= limit_d;
`endif
        end
    end

    assign taus_rst   = taus_rst_q;
    assign u_valid    = u_valid_q;
    assign busy       = busy_q;
    assign seed_err   = seed_err_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_urng_seed_ctrl.sv
// Directed self-checking bench for urng_seed_ctrl (default parameters).
// The sample-limit scenario is compiled only when SAMPLE_LIMIT_EN is defined.
module tb_urng_seed_ctrl;

    localparam logic [31:0] D0 = 32'h1F2E_3D4C;
    localparam logic [31:0] D1 = 32'h5B6A_7988;
    localparam logic [31:0] D2 = 32'h9C8D_7E6F;
    localparam logic [31:0] D3 = 32'h2468_ACE0;
    localparam logic [31:0] D4 = 32'h1357_9BDF;
    localparam logic [31:0] D5 = 32'hFEDC_BA98;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        start;
    logic        stop;
    logic [31:0] s0, s1, s2, s3, s4, s5;
    logic        taus_rst;
    logic        u_valid;
    logic        busy;
    logic        seed_err;
    logic [31:0] sample_cnt;

    int n_asserts = 0;
    int n_fail    = 0;
    int vcount    = 0;

    urng_seed_ctrl #(.WARMUP(16), .LOAD_CYC(2), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .start      (start),
        .stop       (stop),
        .s0         (s0),
        .s1         (s1),
        .s2         (s2),
        .s3         (s3),
        .s4         (s4),
        .s5         (s5),
        .taus_rst   (taus_rst),
        .u_valid    (u_valid),
        .busy       (busy),
        .seed_err   (seed_err),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (u_valid === 1'b1) vcount++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_defaults(input string tag);
        chk({tag, "_s0"}, s0, D0);
        chk({tag, "_s1"}, s1, D1);
        chk({tag, "_s2"}, s2, D2);
        chk({tag, "_s3"}, s3, D3);
        chk({tag, "_s4"}, s4, D4);
        chk({tag, "_s5"}, s5, D5);
    endtask

    task automatic write_cfg(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; stop = 1'b0;
        tick(); tick();
        chk("rst_taus", taus_rst, 1);
        chk("rst_valid", u_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", seed_err, 0);
        chk("rst_cnt", sample_cnt, 0);
        chk_defaults("rst");
        reset = 1'b0;
        tick();

        // Addresses 6 (limit or unused) and 7 never touch the seeds.
        write_cfg(3'd7, 32'h0);
        write_cfg(3'd6, 32'h0);
        chk_defaults("addr67");

        // 1: default seeds, latency profile
        vcount = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            if (i > 1) tick();
            chk("t1_taus", taus_rst, (i < 3) ? 1 : 0);
            chk("t1_valid", u_valid, (i >= 19) ? 1 : 0);
            chk("t1_busy", busy, 1);
        end
        chk_defaults("t1");
        repeat (4) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        chk("t1_stop_busy", busy, 0);
        chk("t1_stop_valid", u_valid, 0);
        chk("t1_stop_taus", taus_rst, 1);
        chk("t1_stop_cnt", sample_cnt, 5);
        chk("t1_vcount", vcount, 5);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("t1_idle_stop_cnt", sample_cnt, 5);

        // 2: illegal seed rejected, then accepted after rewrite
        write_cfg(3'd2, 32'd5);
        chk("t2_s2", s2, 5);
        start = 1'b1; tick(); start = 1'b0;
        chk("t2_bad_busy", busy, 0);
        chk("t2_bad_err", seed_err, 1);
        chk("t2_bad_taus", taus_rst, 1);
        write_cfg(3'd2, 32'd100);
        chk("t2_err_sticky", seed_err, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("t2_ok_busy", busy, 1);
        chk("t2_ok_err", seed_err, 0);
        chk("t2_ok_cnt", sample_cnt, 0);

        // 3: writes frozen while busy
        repeat (18) tick();
        chk("t3_run_valid", u_valid, 1);
        write_cfg(3'd0, 32'hDEAD_BEEF);
        chk("t3_frozen", s0, D0);
        start = 1'b1; tick(); start = 1'b0;
        chk("t3_start_busy_ignored", u_valid, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        write_cfg(3'd0, 32'hDEAD_BEEF);
        chk("t3_write_idle", s0, 32'hDEAD_BEEF);

        // 4: stop during warm-up
        vcount = 0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (9) tick();
        chk("t4_warm_taus", taus_rst, 0);
        chk("t4_warm_busy", busy, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_taus", taus_rst, 1);
        chk("t4_valid", u_valid, 0);
        repeat (15) tick();
        chk("t4_vcount", vcount, 0);
        chk("t4_busy_late", busy, 0);

        // 5: start and stop together in RUN
        vcount = 0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (24) tick();
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_valid", u_valid, 0);
        chk("t5_vcount", vcount, 7);
        chk("t5_cnt", sample_cnt, 7);
        tick();
        chk("t5_busy_hold", busy, 0);
        chk("t5_cnt_hold", sample_cnt, 7);

        // reset mid-run restores defaults
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk_defaults("mrst");
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", u_valid, 0);
        chk("mrst_taus", taus_rst, 1);
        chk("mrst_cnt", sample_cnt, 0);
        tick();

`ifdef SAMPLE_LIMIT_EN
        // 6: sample limit
        write_cfg(3'd6, 32'd100);
        chk_defaults("t6_seeds");
        vcount = 0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (140) tick();
        chk("t6_vcount", vcount, 100);
        chk("t6_cnt", sample_cnt, 100);
        chk("t6_busy", busy, 1);
        chk("t6_taus", taus_rst, 1);
        chk("t6_valid", u_valid, 0);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("t6_stop_busy", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
